// File: rtl/uart_driver.sv
// ---------------------------------------------------------------------------
// uart_driver
//   Bench-side UART transmitter. Bytes arrive over a valid/ready handshake,
//   are queued in a small FIFO and serialised LSB first onto a line that is
//   meant to drive a DUT's RS232 RX pin. Frame: 1 start bit, C_DATA_BITS data
//   bits, optional parity bit, 1 stop bit; each bit lasts exactly DIV clocks.
//
// Ports
//   clk         in   system clock
//   rstn        in   synchronous active-low reset
//   s_data      in   byte to send
//   s_valid     in   s_data valid
//   s_ready     out  FIFO can accept (registered not-full)
//   tx          out  serial line, idle high (registered)
//   busy        out  frame on the line or FIFO non-empty (registered)
//   tx_done     out  one-cycle pulse in the last cycle of each stop bit
//   fifo_count  out  current FIFO occupancy
// ---------------------------------------------------------------------------
module uart_driver #(
    parameter int C_UART_ID     = 0,
    parameter int C_CLK_FREQ_HZ = 100000000,
    parameter int C_BAUDRATE    = 1000000,
    parameter int C_DATA_BITS   = 8,
    parameter int C_USE_PARITY  = 0,
    parameter int C_ODD_PARITY  = 0,
    parameter int C_FIFO_DEPTH  = 4
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic [C_DATA_BITS-1:0]          s_data,
    input  logic                            s_valid,
    output logic                            s_ready,
    output logic                            tx,
    output logic                            busy,
    output logic                            tx_done,
    output logic [$clog2(C_FIFO_DEPTH):0]   fifo_count
);

    // The instance ID is carried only so benches can tell instances apart;
    // folding it in with a zero weight keeps it referenced without effect.
    localparam int unsigned DIV = (C_CLK_FREQ_HZ / C_BAUDRATE) + 0 * C_UART_ID;
    localparam int BW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW = $clog2(C_FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int NB = (C_DATA_BITS > 1) ? $clog2(C_DATA_BITS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [C_DATA_BITS-1:0] r_mem [C_FIFO_DEPTH];
    logic [AW-1:0]          r_wptr;
    logic [AW-1:0]          r_rptr;
    logic [CW-1:0]          r_count;
    logic                   r_ready;

    // ------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------
    state_t                 r_state;
    logic [BW-1:0]          r_baud;
    logic [NB-1:0]          r_bit;
    logic [C_DATA_BITS-1:0] r_shift;
    logic                   r_par;
    logic                   r_tx;
    logic                   r_done;
    logic                   r_busy;

    logic                   w_push;
    logic                   w_pop;
    logic                   w_nonempty;
    logic                   w_bit_end;
    logic [CW-1:0]          w_count_next;

    assign w_push       = s_valid & r_ready;
    assign w_nonempty   = (r_count != '0);
    assign w_bit_end    = (r_baud == BW'(DIV - 1));
    // The FSM takes the FIFO head when idle, or at the very end of a stop
    // bit so back-to-back frames carry no idle gap.
    assign w_pop        = w_nonempty &
                          ((r_state == S_IDLE) | ((r_state == S_STOP) & w_bit_end));
    assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ready <= 1'b1;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_count <= w_count_next;
            r_ready <= (w_count_next != CW'(C_FIFO_DEPTH));
        end
    end

    // Line outputs are registered from the current state, so tx, tx_done
    // and busy trail the state register by exactly one clock. That keeps
    // every bit DIV cycles wide while giving a two-cycle accept-to-start
    // latency.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_tx    <= 1'b1;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_done <= (r_state == S_STOP) && w_bit_end;
            r_busy <= (r_state != S_IDLE) || w_nonempty;

            if (r_state == S_IDLE || w_bit_end) begin
                r_baud <= '0;
            end else begin
                r_baud <= r_baud + BW'(1);
            end

            case (r_state)
                S_IDLE: begin
                    r_tx <= 1'b1;
                    if (w_nonempty) begin
                        r_shift <= r_mem[r_rptr];
                        r_par   <= 1'b0;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    r_tx <= 1'b0;
                    if (w_bit_end) begin
                        r_bit   <= '0;
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    r_tx <= r_shift[0];
                    if (w_bit_end) begin
                        r_par   <= r_par ^ r_shift[0];
                        r_shift <= r_shift >> 1;
                        if (r_bit == NB'(C_DATA_BITS - 1)) begin
                            r_state <= (C_USE_PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            r_bit <= r_bit + NB'(1);
                        end
                    end
                end
                S_PARITY: begin
                    r_tx <= r_par ^ (C_ODD_PARITY != 0);
                    if (w_bit_end) begin
                        r_state <= S_STOP;
                    end
                end
                S_STOP: begin
                    r_tx <= 1'b1;
                    if (w_bit_end) begin
                        if (w_nonempty) begin
                            r_shift <= r_mem[r_rptr];
                            r_par   <= 1'b0;
                            r_state <= S_START;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign s_ready    = r_ready;
    assign tx         = r_tx;
    assign busy       = r_busy;
    assign tx_done    = r_done;
    assign fifo_count = r_count;

endmodule
